// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential 32x32 multiply controller.
// Optional macro MUL_SEQ_HIGH_EN: adds the AH*BH partial product and a 64-bit accumulator.
// Without it, three partial products are issued and only the low 32 product bits are kept.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2,
    RESP  = 2'd3
  } state_t;

`ifdef MUL_SEQ_HIGH_EN
  localparam int PP_COUNT = 4;
  localparam int ACC_W    = 64;
`else
  localparam int PP_COUNT = 3;
  localparam int ACC_W    = 32;
`endif

  // Index of the last partial product issued for one operation.
  localparam logic [1:0] LAST_K = 2'(PP_COUNT - 1);

  // Left shift applied to each partial product before accumulation.
  localparam logic [5:0] SHIFT_K0 = 6'd0;   // AL*BL
  localparam logic [5:0] SHIFT_K1 = 6'd16;  // AL*BH
  localparam logic [5:0] SHIFT_K2 = 6'd16;  // AH*BL
  localparam logic [5:0] SHIFT_K3 = 6'd32;  // AH*BH

  function automatic logic [5:0] pp_shift(input logic [1:0] k);
    case (k)
      2'd0:    return SHIFT_K0;
      2'd1:    return SHIFT_K1;
      2'd2:    return SHIFT_K2;
      default: return SHIFT_K3;
    endcase
  endfunction

  // Shift a 32-bit partial product into accumulator position; bits above ACC_W wrap away.
  function automatic logic [ACC_W-1:0] pp_term(input logic [31:0] pp, input logic [5:0] shift);
    return ACC_W'({32'b0, pp} << shift);
  endfunction

endpackage

// File: rtl/mul_seq_cell16.sv
// Purpose: registered 16x16 unsigned multiplier cell, one DSP block.
// Latency: 1 cycle from a/b with en to p.
// Backpressure: none; holds p while en is low, clr zeroes p synchronously.
module mul_seq_cell16 (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  // Product register: clear wins over enable.
  always_ff @(posedge clk) begin
    if (clr) begin
      p <= '0;
    end else if (en) begin
      p <= {16'b0, a} * {16'b0, b};
    end
  end

endmodule

// File: rtl/mul_seq_arbiter.sv
// Purpose: round-robin shared 32x32 multiply, one 16x16 cell time-shared among NUM_REQ requesters.
// Latency: rsp_valid 5 cycles after the request handshake (6 with MUL_SEQ_HIGH_EN, which adds rsp_hi).
// Backpressure: one op in flight; req_ready all-zero outside IDLE, result held in RESP until rsp_ready.
module mul_seq_arbiter
  import mul_seq_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_lo
`ifdef MUL_SEQ_HIGH_EN
  ,
  output logic [31:0]           rsp_hi
`endif
);

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_q;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic [1:0]        k;
  logic [5:0]        shift_q;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;

  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   next_ptr;
  logic [31:0]       grant_a;
  logic [31:0]       grant_b;

  logic [15:0]       cell_a;
  logic [15:0]       cell_b;
  logic [31:0]       cell_p;
  logic              cell_en;
  logic              acc_en;

  // Round-robin pick: smallest upward distance from rr_ptr among asserted requests.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    next_ptr    = '0;
    grant_a     = '0;
    grant_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!grant_found && req_valid[j] && (j == (int'(rr_ptr) + i) % NUM_REQ)) begin
          grant_found = 1'b1;
          grant_id    = ID_W'(j);
          next_ptr    = ID_W'((j + 1) % NUM_REQ);
          grant_a     = req_a[32*j +: 32];
          grant_b     = req_b[32*j +: 32];
        end
      end
    end
  end

  // Accept only the winner, only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && !reset && grant_found) begin
      req_ready = NUM_REQ'(1) << grant_id;
    end
  end

  // k selects halves: bit1 picks the A half, bit0 the B half (k0 LL, k1 LH, k2 HL, k3 HH).
  assign cell_a  = k[1] ? op_a[31:16] : op_a[15:0];
  assign cell_b  = k[0] ? op_b[31:16] : op_b[15:0];
  assign cell_en = (state == ISSUE);

  // The cell output lags one cycle, so the first ISSUE cycle has nothing to add yet.
  assign acc_en  = ((state == ISSUE) && (k != 2'd0)) || (state == FLUSH);
  assign acc_sum = acc + pp_term(cell_p, shift_q);

  mul_seq_cell16 u_cell (
    .clk (clk),
    .clr (reset),
    .en  (cell_en),
    .a   (cell_a),
    .b   (cell_b),
    .p   (cell_p)
  );

  // Control FSM with accumulator and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      op_a      <= '0;
      op_b      <= '0;
      k         <= '0;
      shift_q   <= '0;
      acc       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_lo    <= '0;
`ifdef MUL_SEQ_HIGH_EN
      rsp_hi    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_a   <= grant_a;
            op_b   <= grant_b;
            id_q   <= grant_id;
            rr_ptr <= next_ptr;
            acc    <= '0;
            k      <= '0;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (acc_en) begin
            acc <= acc_sum;
          end
          // Remember where the product now entering the cell must land next cycle.
          shift_q <= pp_shift(k);
          if (k == LAST_K) begin
            state <= FLUSH;
          end else begin
            k <= k + 2'd1;
          end
        end
        FLUSH: begin
          acc       <= acc_sum;
          rsp_lo    <= acc_sum[31:0];
`ifdef MUL_SEQ_HIGH_EN
          rsp_hi    <= acc_sum[63:32];
`endif
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_arbiter.sv
// Randomized bench for mul_seq_arbiter against a product/round-robin reference model.
// Builds in either configuration; MUL_SEQ_HIGH_EN enables the rsp_hi checks and 6-cycle latency.
// Each scenario task drives its own stimulus and compares outputs inline.
module tb_mul_seq_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ID_W    = 3;
`ifdef MUL_SEQ_HIGH_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a = '0;
  logic [32*NUM_REQ-1:0] req_b = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_lo;
`ifdef MUL_SEQ_HIGH_EN
  logic [31:0]           rsp_hi;
`endif

  int n_vec = 0;
  int n_err = 0;
  int m_ptr = 0;   // reference round-robin pointer

  mul_seq_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_lo    (rsp_lo)
`ifdef MUL_SEQ_HIGH_EN
    ,
    .rsp_hi    (rsp_hi)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first valid at or after ptr, wrapping.
  function automatic int model_grant(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic scramble_operands();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[32*i +: 32] = $urandom;
      req_b[32*i +: 32] = $urandom;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rsp_ready = 1'b0;
    scramble_operands();
    req_valid = '1;
    tick();
    tick();
    n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    n_vec++; if (rsp_id !== '0) begin n_err++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
    n_vec++; if (rsp_lo !== 32'h0) begin n_err++; $display("FAIL reset_rsp_lo got=%h want=0", rsp_lo); end
`ifdef MUL_SEQ_HIGH_EN
    n_vec++; if (rsp_hi !== 32'h0) begin n_err++; $display("FAIL reset_rsp_hi got=%h want=0", rsp_hi); end
`endif
    req_valid = '0;
    reset = 1'b0;
    m_ptr = 0;
    tick();
  endtask

  // Single-requester products: directed corner operands first, then random ones.
  task automatic test_products();
    logic [31:0] a, b;
    logic [63:0] prod;
    int r, lat;
    bit got;
    for (int t = 0; t < 14; t++) begin
      a = $urandom;
      b = $urandom;
      r = $urandom_range(0, NUM_REQ - 1);
      case (t)
        0: begin a = 32'd3; b = 32'd5; r = 0; end
        1: begin a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; end
        2: begin a = 32'h00012345; b = 32'h00010000; end
        3: a = 32'h0;
        4: b = 32'h1;
        5: begin a = 32'hFFFF0000; b = 32'h0000FFFF; end
        default: ;
      endcase
      prod = {32'b0, a} * {32'b0, b};
      scramble_operands();
      req_a[32*r +: 32] = a;
      req_b[32*r +: 32] = b;
      req_valid = '0;
      req_valid[r] = 1'b1;
      got = 0;
      for (int c = 0; c < 10; c++) begin
        #1;
        if (req_ready !== '0) begin got = 1; break; end
        tick();
      end
      n_vec++;
      if (!got || req_ready !== (NUM_REQ'(1) << r)) begin
        n_err++; $display("FAIL prod_grant t=%0d got=%b want=%b", t, req_ready, NUM_REQ'(1) << r);
      end
      m_ptr = (r + 1) % NUM_REQ;
      tick();
      req_valid = '0;
      scramble_operands();
      lat = -1;
      for (int n = 1; n <= 12; n++) begin
        #1;
        if (rsp_valid === 1'b1) begin lat = n; break; end
        tick();
      end
      n_vec++; if (lat != LAT) begin n_err++; $display("FAIL prod_latency t=%0d got=%0d want=%0d", t, lat, LAT); end
      n_vec++; if (rsp_lo !== prod[31:0]) begin n_err++; $display("FAIL prod_lo t=%0d a=%h b=%h got=%h want=%h", t, a, b, rsp_lo, prod[31:0]); end
      n_vec++; if (rsp_id !== ID_W'(r)) begin n_err++; $display("FAIL prod_id t=%0d got=%0d want=%0d", t, rsp_id, r); end
`ifdef MUL_SEQ_HIGH_EN
      n_vec++; if (rsp_hi !== prod[63:32]) begin n_err++; $display("FAIL prod_hi t=%0d got=%h want=%h", t, rsp_hi, prod[63:32]); end
`endif
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      #1;
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL prod_rsp_drop t=%0d got=%b want=0", t, rsp_valid); end
    end
  endtask

  // Requesters 0 and 1 held valid from reset: grants must alternate and follow the model.
  task automatic test_round_robin();
    logic [31:0] a, b;
    logic [63:0] prod;
    int g, lat;
    bit got;
    reset = 1'b1;
    scramble_operands();
    req_valid = 3'b011;
    tick();
    tick();
    reset = 1'b0;
    m_ptr = 0;
    for (int op = 0; op < 6; op++) begin
      got = 0;
      for (int c = 0; c < 10; c++) begin
        #1;
        n_vec++; if ($countones(req_ready) > 1) begin n_err++; $display("FAIL rr_onehot op=%0d got=%b want=onehot", op, req_ready); end
        if (req_ready !== '0) begin got = 1; break; end
        tick();
      end
      g = model_grant(req_valid, m_ptr);
      n_vec++;
      if (!got || req_ready !== (NUM_REQ'(1) << g)) begin
        n_err++; $display("FAIL rr_grant op=%0d got=%b want=%b", op, req_ready, NUM_REQ'(1) << g);
      end
      a = req_a[32*g +: 32];
      b = req_b[32*g +: 32];
      prod = {32'b0, a} * {32'b0, b};
      m_ptr = (g + 1) % NUM_REQ;
      tick();
      req_a[32*g +: 32] = $urandom;
      req_b[32*g +: 32] = $urandom;
      lat = -1;
      for (int n = 1; n <= 12; n++) begin
        #1;
        if (rsp_valid === 1'b1) begin lat = n; break; end
        n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL rr_busy_ready op=%0d got=%b want=0", op, req_ready); end
        tick();
      end
      n_vec++; if (lat != LAT) begin n_err++; $display("FAIL rr_latency op=%0d got=%0d want=%0d", op, lat, LAT); end
      n_vec++; if (rsp_id !== ID_W'(g)) begin n_err++; $display("FAIL rr_id op=%0d got=%0d want=%0d", op, rsp_id, g); end
      n_vec++; if (rsp_lo !== prod[31:0]) begin n_err++; $display("FAIL rr_lo op=%0d got=%h want=%h", op, rsp_lo, prod[31:0]); end
`ifdef MUL_SEQ_HIGH_EN
      n_vec++; if (rsp_hi !== prod[63:32]) begin n_err++; $display("FAIL rr_hi op=%0d got=%h want=%h", op, rsp_hi, prod[63:32]); end
`endif
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    req_valid = '0;
    tick();
  endtask

  // Result held under backpressure; no grant in the response handshake cycle, one the cycle after.
  task automatic test_backpressure();
    logic [31:0] a, b;
    logic [63:0] prod;
    int g, lat;
    bit got;
    a = $urandom;
    b = $urandom;
    prod = {32'b0, a} * {32'b0, b};
    scramble_operands();
    req_a[32*2 +: 32] = a;
    req_b[32*2 +: 32] = b;
    req_valid = 3'b100;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_ready !== '0) begin got = 1; break; end
      tick();
    end
    n_vec++; if (!got || req_ready !== 3'b100) begin n_err++; $display("FAIL bp_grant got=%b want=100", req_ready); end
    m_ptr = 0;
    tick();
    req_valid = '0;
    lat = -1;
    for (int n = 1; n <= 12; n++) begin
      #1;
      if (rsp_valid === 1'b1) begin lat = n; break; end
      tick();
    end
    n_vec++; if (lat != LAT) begin n_err++; $display("FAIL bp_latency got=%0d want=%0d", lat, LAT); end
    req_valid = '1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid c=%0d got=%b want=1", c, rsp_valid); end
      n_vec++; if (rsp_lo !== prod[31:0]) begin n_err++; $display("FAIL bp_hold_lo c=%0d got=%h want=%h", c, rsp_lo, prod[31:0]); end
      n_vec++; if (rsp_id !== ID_W'(2)) begin n_err++; $display("FAIL bp_hold_id c=%0d got=%0d want=2", c, rsp_id); end
      n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL bp_hold_ready c=%0d got=%b want=0", c, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL bp_hs_ready got=%b want=0", req_ready); end
    tick();
    rsp_ready = 1'b0;
    #1;
    g = model_grant(req_valid, m_ptr);
    n_vec++; if (req_ready !== (NUM_REQ'(1) << g)) begin n_err++; $display("FAIL bp_next_grant got=%b want=%b", req_ready, NUM_REQ'(1) << g); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_rsp_drop got=%b want=0", rsp_valid); end
    req_valid = '0;
    tick();
  endtask

  // Reset during ISSUE aborts; afterwards the pointer restarts at 0 and 7*9 completes normally.
  task automatic test_reset_abort();
    int lat;
    bit got;
    scramble_operands();
    req_valid = 3'b001;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_ready !== '0) begin got = 1; break; end
      tick();
    end
    n_vec++; if (!got || req_ready !== 3'b001) begin n_err++; $display("FAIL abort_first_grant got=%b want=001", req_ready); end
    m_ptr = 1;
    tick();
    req_valid = '0;
    tick();
    req_a[31:0] = 32'd7;
    req_b[31:0] = 32'd9;
    req_valid = 3'b011;
    reset = 1'b1;
    #1;
    n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL abort_issue_ready got=%b want=0", req_ready); end
    tick();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL abort_rsp_valid got=%b want=0", rsp_valid); end
    n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL abort_reset_ready got=%b want=0", req_ready); end
    reset = 1'b0;
    m_ptr = 0;
    #1;
    n_vec++; if (req_ready !== (NUM_REQ'(1) << model_grant(req_valid, m_ptr))) begin
      n_err++; $display("FAIL abort_regrant got=%b want=%b", req_ready, NUM_REQ'(1) << model_grant(req_valid, m_ptr));
    end
    m_ptr = 1;
    tick();
    req_valid = '0;
    lat = -1;
    for (int n = 1; n <= 12; n++) begin
      #1;
      if (rsp_valid === 1'b1) begin lat = n; break; end
      tick();
    end
    n_vec++; if (lat != LAT) begin n_err++; $display("FAIL abort_latency got=%0d want=%0d", lat, LAT); end
    n_vec++; if (rsp_lo !== 32'h3F) begin n_err++; $display("FAIL abort_lo got=%h want=0000003f", rsp_lo); end
    n_vec++; if (rsp_id !== '0) begin n_err++; $display("FAIL abort_id got=%0d want=0", rsp_id); end
`ifdef MUL_SEQ_HIGH_EN
    n_vec++; if (rsp_hi !== 32'h0) begin n_err++; $display("FAIL abort_hi got=%h want=0", rsp_hi); end
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_products();
    test_round_robin();
    test_backpressure();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
